bypass_scoreboard: RTL and testbench
====================================

// Module: bypass_scoreboard
// PURPOSE
//  Generalised operand bypass network. Sits beside ID. Takes writeback info from NUM_STG producer stages (EXE, MEM, WB, ...) and
//  serves NUM_RP register read ports with the newest in-flight value, or with regfile data when no stage matches.
//  Aligns load data in LD_STG (byte/half/word, signed/unsigned). Keeps a scoreboard of long-latency ops (mul/div) that leave
//  the pipeline. Raises stall when a needed value is not yet available.
// PARAMETERS
//  NUM_STG  3   number of producer stages; index 0 = youngest (EXE)
//  NUM_RP   2   number of register read ports
//  DATA_W   32  register data width
//  ADDR_W   5   register address width; 2**ADDR_W scoreboard entries
//  LD_STG   1   stage index whose data is raw load data needing alignment
//  CNT_W    32  stall performance counter width
// PORTS
//  clk          in   1                clock
//  reset        in   1                async active-high reset
//  stg_wen      in   NUM_STG          stage i writes a register (valid & rf_we)
//  stg_rdy      in   NUM_STG          stage i data is final this cycle
//  stg_waddr    in   NUM_STG*ADDR_W   dest reg of stage i (slice i)
//  stg_wdata    in   NUM_STG*DATA_W   result of stage i; raw 32-bit word for LD_STG
//  ld_ben       in   4                byte enables of load in LD_STG
//  ld_uns       in   1                1 = zero-extend, 0 = sign-extend
//  rd_en        in   NUM_RP           read port p in use
//  rd_addr      in   NUM_RP*ADDR_W    source reg per port
//  rf_rdata     in   NUM_RP*DATA_W    regfile read data per port
//  ll_issue     in   1                long-latency op issued this cycle
//  ll_iaddr     in   ADDR_W           its dest reg
//  ll_done      in   1                long-latency result returns this cycle
//  ll_daddr     in   ADDR_W           returning dest reg
//  ll_wdata     in   DATA_W           returning result
//  flush        in   1                pipeline flush; cancels scoreboard
//  rd_data      out  NUM_RP*DATA_W    operand per port
//  rd_fwd       out  NUM_RP           port p served from bypass, not regfile
//  stall        out  1                ID must hold
//  sb_err       out  1                sticky: issue to already-pending reg
//  stall_cnt    out  CNT_W            cycles with stall=1
// BEHAVIOUR
//  Reset (async, active-high): pending[] = 0, sb_err = 0, stall_cnt = 0. Comb outputs follow the inputs at once.
//  Load alignment (comb) on LD_STG data. ben 0001/0010/0100/1000 -> byte 0..3. ben 0011/1100 -> half 0/1. ben 1111 -> word.
//   Byte/half are extended per ld_uns. Any other ben -> 0.
//  Per port p (comb, zero latency), with a = rd_addr[p]:
//   - a==0 or rd_en[p]==0: rd_data = 0 if a==0, else rf_rdata; no stall, rd_fwd = 0.
//   - Else take the lowest index i with stg_wen[i] & stg_waddr[i]==a (youngest wins).
//     If stg_rdy[i]: rd_data = stage i data (aligned if i==LD_STG), rd_fwd = 1. Else stall.
//   - No stage match, ll_done & ll_daddr==a: rd_data = ll_wdata, rd_fwd = 1.
//   - No match, pending[a] = 1 (and not done this cycle): stall.
//   - Otherwise rd_data = rf_rdata[p], rd_fwd = 0.
//  stall = OR over ports. Data outputs are don't-care while stall=1.
//  Scoreboard (posedge clk):
//   - ll_done clears pending[ll_daddr].
//   - ll_issue sets pending[ll_iaddr].
//   - Same addr both: set wins.
//   - ll_iaddr==0: ignored.
//   - ll_issue to a pending reg (not cleared same cycle): sb_err <= 1, pending stays 1.
//   - flush: pending <= 0. An ll_issue in the same cycle is discarded.
//   - ll_done for a non-pending reg: no state change; data still forwarded that cycle.
//  stall_cnt += 1 each cycle stall=1; wraps at 2**CNT_W-1 -> 0. sb_err and stall_cnt clear only on reset.
// TESTING
//  EXE wen x5=0x11, MEM wen x5=0x22, rd_addr0=5 -> rd_data0=0x11, rd_fwd0=1, stall=0.
//  MEM load raw 0x80FF7F00, ben=0010, uns=0, rd x7 matches -> 0x0000007F. ben=1000, uns=0 -> 0xFFFFFF80. ben=1100, uns=1 -> 0x000080FF.
//  EXE wen x3 rdy=0, rd x3 -> stall=1, stall_cnt increments. Next cycle rdy=1 -> stall=0, data forwarded.
//  ll_issue x9; read x9 for 4 cycles -> stall=1 each cycle. ll_done x9 with 0xDEAD -> rd_data=0xDEAD, stall=0; next cycle pending[9]=0.
//  ll_issue x9 twice without done -> sb_err=1. flush -> pending cleared, read x9 -> rf_rdata. Reset mid-stall -> all state 0.
//  rd_addr=0 with EXE wen x0=0x55 -> rd_data=0, rd_fwd=0. CNT_W=4 with 17 stall cycles -> stall_cnt=1.

Source files
------------

// File: rtl/bypass_scoreboard_if.sv
// Bus bundle for the operand bypass / long-latency scoreboard block.
// The master side drives producer-stage writeback info, read-port requests
// and long-latency issue/return events; the slave side (the bypass block)
// returns operands, the forward flags, the stall request and the status/perf outputs.
interface bypass_scoreboard_if #(
  parameter int NUM_STG = 3,
  parameter int NUM_RP  = 2,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int CNT_W   = 32
);

  // producer stages, slice i belongs to stage i (0 = youngest)
  logic [NUM_STG-1:0]        stg_wen;
  logic [NUM_STG-1:0]        stg_rdy;
  logic [NUM_STG*ADDR_W-1:0] stg_waddr;
  logic [NUM_STG*DATA_W-1:0] stg_wdata;

  // load qualifiers for the stage carrying raw load data
  logic [3:0]                ld_ben;
  logic                      ld_uns;

  // register read ports
  logic [NUM_RP-1:0]         rd_en;
  logic [NUM_RP*ADDR_W-1:0]  rd_addr;
  logic [NUM_RP*DATA_W-1:0]  rf_rdata;

  // long-latency unit
  logic                      ll_issue;
  logic [ADDR_W-1:0]         ll_iaddr;
  logic                      ll_done;
  logic [ADDR_W-1:0]         ll_daddr;
  logic [DATA_W-1:0]         ll_wdata;
  logic                      flush;

  // results
  logic [NUM_RP*DATA_W-1:0]  rd_data;
  logic [NUM_RP-1:0]         rd_fwd;
  logic                      stall;
  logic                      sb_err;
  logic [CNT_W-1:0]          stall_cnt;

  modport master (
    output stg_wen, stg_rdy, stg_waddr, stg_wdata,
    output ld_ben, ld_uns,
    output rd_en, rd_addr, rf_rdata,
    output ll_issue, ll_iaddr, ll_done, ll_daddr, ll_wdata, flush,
    input  rd_data, rd_fwd, stall, sb_err, stall_cnt
  );

  modport slave (
    input  stg_wen, stg_rdy, stg_waddr, stg_wdata,
    input  ld_ben, ld_uns,
    input  rd_en, rd_addr, rf_rdata,
    input  ll_issue, ll_iaddr, ll_done, ll_daddr, ll_wdata, flush,
    output rd_data, rd_fwd, stall, sb_err, stall_cnt
  );

endinterface

// File: rtl/bypass_scoreboard.sv
// Operand bypass network with a scoreboard for long-latency results.
// Each read port gets the newest in-flight value for its source register:
// the youngest matching producer stage first, then a long-latency result
// returning this cycle, and otherwise the register file. A port stalls when
// its youngest producer is not final yet or a long-latency op still owns
// the register. Raw load data in LD_STG is aligned before it is forwarded.
// Alignment assumes DATA_W >= 32 (the raw load word is the low 32 bits).
module bypass_scoreboard #(
  parameter int NUM_STG = 3,
  parameter int NUM_RP  = 2,
  parameter int DATA_W  = 32,
  parameter int ADDR_W  = 5,
  parameter int LD_STG  = 1,
  parameter int CNT_W   = 32
) (
  input  logic               clk,
  input  logic               reset,
  bypass_scoreboard_if.slave bus
);

  localparam int NUM_REGS = 2 ** ADDR_W;

  // scoreboard and status state
  logic [NUM_REGS-1:0]      pending_q, pending_d;
  logic                     sb_err_q, sb_err_d;
  logic [CNT_W-1:0]         stall_cnt_q, stall_cnt_d;

  // load alignment
  logic [31:0]              ld_raw;
  logic [31:0]              ld_al32;
  logic [DATA_W-1:0]        ld_data;

  // per-port lookup temporaries and results
  logic [ADDR_W-1:0]        addr_p;
  logic                     hit;
  logic                     hit_rdy;
  logic [DATA_W-1:0]        hit_data;
  logic [NUM_RP*DATA_W-1:0] rd_data_c;
  logic [NUM_RP-1:0]        rd_fwd_c;
  logic [NUM_RP-1:0]        port_stall;
  logic                     stall_c;

  // Extract the addressed byte/half/word of the raw load word and extend it
  always_comb begin
    ld_raw  = bus.stg_wdata[LD_STG*DATA_W +: 32];
    ld_al32 = '0;
    case (bus.ld_ben)
      4'b0001: ld_al32 = {{24{~bus.ld_uns & ld_raw[7]}},  ld_raw[7:0]};
      4'b0010: ld_al32 = {{24{~bus.ld_uns & ld_raw[15]}}, ld_raw[15:8]};
      4'b0100: ld_al32 = {{24{~bus.ld_uns & ld_raw[23]}}, ld_raw[23:16]};
      4'b1000: ld_al32 = {{24{~bus.ld_uns & ld_raw[31]}}, ld_raw[31:24]};
      4'b0011: ld_al32 = {{16{~bus.ld_uns & ld_raw[15]}}, ld_raw[15:0]};
      4'b1100: ld_al32 = {{16{~bus.ld_uns & ld_raw[31]}}, ld_raw[31:16]};
      4'b1111: ld_al32 = ld_raw;
      default: ld_al32 = '0;
    endcase
    ld_data = DATA_W'(ld_al32);
  end

  // Resolve every read port: youngest stage, then returning long-latency result, then regfile
  always_comb begin
    rd_data_c  = '0;
    rd_fwd_c   = '0;
    port_stall = '0;
    addr_p     = '0;
    hit        = 1'b0;
    hit_rdy    = 1'b0;
    hit_data   = '0;
    for (int p = 0; p < NUM_RP; p++) begin
      addr_p   = bus.rd_addr[p*ADDR_W +: ADDR_W];
      hit      = 1'b0;
      hit_rdy  = 1'b0;
      hit_data = '0;
      // walk oldest to youngest so the youngest match is the one left standing
      for (int i = NUM_STG - 1; i >= 0; i--) begin
        if (bus.stg_wen[i] && (bus.stg_waddr[i*ADDR_W +: ADDR_W] == addr_p)) begin
          hit      = 1'b1;
          hit_rdy  = bus.stg_rdy[i];
          hit_data = (i == LD_STG) ? ld_data : bus.stg_wdata[i*DATA_W +: DATA_W];
        end
      end

      if (addr_p == '0) begin
        rd_data_c[p*DATA_W +: DATA_W] = '0;
      end else if (!bus.rd_en[p]) begin
        rd_data_c[p*DATA_W +: DATA_W] = bus.rf_rdata[p*DATA_W +: DATA_W];
      end else if (hit) begin
        if (hit_rdy) begin
          rd_data_c[p*DATA_W +: DATA_W] = hit_data;
          rd_fwd_c[p]                   = 1'b1;
        end else begin
          port_stall[p] = 1'b1;
        end
      end else if (bus.ll_done && (bus.ll_daddr == addr_p)) begin
        rd_data_c[p*DATA_W +: DATA_W] = bus.ll_wdata;
        rd_fwd_c[p]                   = 1'b1;
      end else if (pending_q[addr_p]) begin
        port_stall[p] = 1'b1;
      end else begin
        rd_data_c[p*DATA_W +: DATA_W] = bus.rf_rdata[p*DATA_W +: DATA_W];
      end
    end
    stall_c = |port_stall;
  end

  // Next scoreboard, sticky error and stall counter values
  always_comb begin
    pending_d   = pending_q;
    sb_err_d    = sb_err_q;
    stall_cnt_d = stall_cnt_q;

    if (bus.flush) begin
      // a flush drops everything in flight, including an issue in this cycle
      pending_d = '0;
    end else begin
      if (bus.ll_done) begin
        pending_d[bus.ll_daddr] = 1'b0;
      end
      if (bus.ll_issue && (bus.ll_iaddr != '0)) begin
        // re-issuing to a register whose result is returning this cycle is legal
        if (pending_q[bus.ll_iaddr] &&
            !(bus.ll_done && (bus.ll_daddr == bus.ll_iaddr))) begin
          sb_err_d = 1'b1;
        end
        pending_d[bus.ll_iaddr] = 1'b1;
      end
    end

    if (stall_c) begin
      stall_cnt_d = stall_cnt_q + 1'b1;
    end
  end

  // State registers
  always_ff @(posedge clk or posedge reset) begin
    if (reset) begin
      pending_q   <= '0;
      sb_err_q    <= 1'b0;
      stall_cnt_q <= '0;
    end else begin
      pending_q   <= pending_d;
      sb_err_q    <= sb_err_d;
      stall_cnt_q <= stall_cnt_d;
    end
  end

  assign bus.rd_data   = rd_data_c;
  assign bus.rd_fwd    = rd_fwd_c;
  assign bus.stall     = stall_c;
  assign bus.sb_err    = sb_err_q;
  assign bus.stall_cnt = stall_cnt_q;

endmodule

// File: tb/tb_bypass_scoreboard.sv
// Bench for bypass_scoreboard: a table of per-cycle vectors with expected
// outputs, pushed to an expectation queue as each vector is driven and popped
// when the outputs are sampled, plus hand-built sequences for async reset
// and the narrow stall counter wrap.
module tb_bypass_scoreboard;

  localparam int NS = 3;
  localparam int NP = 2;
  localparam int DW = 32;
  localparam int AW = 5;
  localparam int CW = 4;

  typedef struct {
    string                name;
    logic [NS-1:0]        wen;
    logic [NS-1:0]        rdy;
    logic [NS-1:0][AW-1:0] waddr;
    logic [NS-1:0][DW-1:0] wdata;
    logic [3:0]           ben;
    logic                 uns;
    logic [NP-1:0]        rden;
    logic [NP-1:0][AW-1:0] raddr;
    logic [NP-1:0][DW-1:0] rf;
    logic                 issue;
    logic [AW-1:0]        iaddr;
    logic                 done;
    logic [AW-1:0]        daddr;
    logic [DW-1:0]        lldata;
    logic                 flush;
    logic [NP-1:0][DW-1:0] expData;
    logic [NP-1:0]        expFwd;
    logic                 expStall;
    logic                 expErr;
  } vec_t;

  logic clk;
  logic reset;

  bypass_scoreboard_if #(
    .NUM_STG(NS), .NUM_RP(NP), .DATA_W(DW), .ADDR_W(AW), .CNT_W(CW)
  ) bus ();

  bypass_scoreboard #(
    .NUM_STG(NS), .NUM_RP(NP), .DATA_W(DW), .ADDR_W(AW), .LD_STG(1), .CNT_W(CW)
  ) dut (
    .clk  (clk),
    .reset(reset),
    .bus  (bus)
  );

  vec_t       vecs[$];
  vec_t       expQ[$];
  int         checks   = 0;
  int         failures = 0;
  logic [CW-1:0] expStallCnt;
  logic       curErr;

  // free-running clock, period 10
  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic vec_t idle(input string n);
    vec_t v;
    v.name     = n;
    v.wen      = '0;
    v.rdy      = '1;
    v.waddr    = '0;
    v.wdata    = '0;
    v.ben      = 4'b1111;
    v.uns      = 1'b0;
    v.rden     = '0;
    v.raddr    = '0;
    v.rf       = '0;
    v.issue    = 1'b0;
    v.iaddr    = '0;
    v.done     = 1'b0;
    v.daddr    = '0;
    v.lldata   = '0;
    v.flush    = 1'b0;
    v.expData  = '0;
    v.expFwd   = '0;
    v.expStall = 1'b0;
    v.expErr   = 1'b0;
    return v;
  endfunction

  // idle vector with port 0 reading register a; regfile supplies d
  function automatic vec_t rd0(input string n, input logic [AW-1:0] a, input logic [DW-1:0] d);
    vec_t v;
    v            = idle(n);
    v.rden[0]    = 1'b1;
    v.raddr[0]   = a;
    v.rf[0]      = d;
    v.expData[0] = d;
    return v;
  endfunction

  task automatic addVec(input vec_t v);
    v.expErr = curErr;
    vecs.push_back(v);
  endtask

  task automatic driveInputs(input vec_t v);
    bus.stg_wen   = v.wen;
    bus.stg_rdy   = v.rdy;
    bus.stg_waddr = v.waddr;
    bus.stg_wdata = v.wdata;
    bus.ld_ben    = v.ben;
    bus.ld_uns    = v.uns;
    bus.rd_en     = v.rden;
    bus.rd_addr   = v.raddr;
    bus.rf_rdata  = v.rf;
    bus.ll_issue  = v.issue;
    bus.ll_iaddr  = v.iaddr;
    bus.ll_done   = v.done;
    bus.ll_daddr  = v.daddr;
    bus.ll_wdata  = v.lldata;
    bus.flush     = v.flush;
  endtask

  task automatic applyStimulus(input vec_t v);
    driveInputs(v);
    expQ.push_back(v);
  endtask

  task automatic compareField(input string vname, input string what,
                              input logic [31:0] act, input logic [31:0] exp);
    checks++;
    if (act !== exp) begin
      failures++;
      $display("[TB] FAIL %s/%s: got 0x%0h, want 0x%0h", vname, what, act, exp);
    end
  endtask

  task automatic checkOutput();
    vec_t e;
    checks++;
    if (expQ.size() == 0) begin
      failures++;
      $display("[TB] FAIL expect_queue: got empty, want one entry");
      return;
    end
    e = expQ.pop_front();
    compareField(e.name, "stall",     32'(bus.stall),     32'(e.expStall));
    compareField(e.name, "sb_err",    32'(bus.sb_err),    32'(e.expErr));
    compareField(e.name, "stall_cnt", 32'(bus.stall_cnt), 32'(expStallCnt));
    if (!e.expStall) begin
      compareField(e.name, "rd_data0", bus.rd_data[31:0],  e.expData[0]);
      compareField(e.name, "rd_data1", bus.rd_data[63:32], e.expData[1]);
      compareField(e.name, "rd_fwd",   32'(bus.rd_fwd),    32'(e.expFwd));
    end
    if (e.expStall) expStallCnt = expStallCnt + 1'b1;
  endtask

  // drive at the falling edge, sample 2 time units later, state moves at the next rising edge
  task automatic runVec(input vec_t v);
    @(negedge clk);
    applyStimulus(v);
    #2;
    checkOutput();
  endtask

  task automatic addLoad(input string n, input logic [3:0] ben, input logic uns,
                         input logic [DW-1:0] exp);
    vec_t v;
    v            = rd0(n, 5'd7, 32'h0000_1234);
    v.wen        = 3'b010;
    v.waddr[1]   = 5'd7;
    v.wdata[1]   = 32'h80FF_7F00;
    v.ben        = ben;
    v.uns        = uns;
    v.expData[0] = exp;
    v.expFwd     = 2'b01;
    addVec(v);
  endtask

  initial begin
    vec_t v;
    expStallCnt = '0;
    curErr      = 1'b0;

    // ---------------- vector table ----------------
    v = rd0("exe_youngest", 5'd5, 32'h0000_AAAA);
    v.wen = 3'b011; v.waddr[0] = 5'd5; v.waddr[1] = 5'd5;
    v.wdata[0] = 32'h11; v.wdata[1] = 32'h22;
    v.rden[1] = 1'b1; v.raddr[1] = 5'd6; v.rf[1] = 32'h6666; v.expData[1] = 32'h6666;
    v.expData[0] = 32'h11; v.expFwd = 2'b01;
    addVec(v);

    v = rd0("mem_word", 5'd5, 32'h0000_AAAA);
    v.wen = 3'b010; v.waddr[1] = 5'd5; v.wdata[1] = 32'h22;
    v.expData[0] = 32'h22; v.expFwd = 2'b01;
    addVec(v);

    v = rd0("exe_and_wb", 5'd2, 32'h0000_0002);
    v.wen = 3'b101; v.waddr[0] = 5'd2; v.wdata[0] = 32'hA2;
    v.waddr[2] = 5'd8; v.wdata[2] = 32'h1234_5678;
    v.rden[1] = 1'b1; v.raddr[1] = 5'd8; v.rf[1] = 32'h8;
    v.expData[0] = 32'hA2; v.expData[1] = 32'h1234_5678; v.expFwd = 2'b11;
    addVec(v);

    addLoad("ld_b1_s",  4'b0010, 1'b0, 32'h0000_007F);
    addLoad("ld_b3_s",  4'b1000, 1'b0, 32'hFFFF_FF80);
    addLoad("ld_h1_u",  4'b1100, 1'b1, 32'h0000_80FF);
    addLoad("ld_h1_s",  4'b1100, 1'b0, 32'hFFFF_80FF);
    addLoad("ld_b0_s",  4'b0001, 1'b0, 32'h0000_0000);
    addLoad("ld_b2_s",  4'b0100, 1'b0, 32'hFFFF_FFFF);
    addLoad("ld_b2_u",  4'b0100, 1'b1, 32'h0000_00FF);
    addLoad("ld_b3_u",  4'b1000, 1'b1, 32'h0000_0080);
    addLoad("ld_h0_s",  4'b0011, 1'b0, 32'h0000_7F00);
    addLoad("ld_word",  4'b1111, 1'b0, 32'h80FF_7F00);
    addLoad("ld_bad",   4'b0101, 1'b0, 32'h0000_0000);
    addLoad("ld_none",  4'b0000, 1'b1, 32'h0000_0000);

    v = rd0("exe_not_aligned", 5'd7, 32'h0000_1234);
    v.wen = 3'b001; v.waddr[0] = 5'd7; v.wdata[0] = 32'h80FF_7F00; v.ben = 4'b0010;
    v.expData[0] = 32'h80FF_7F00; v.expFwd = 2'b01;
    addVec(v);

    v = rd0("read_x0", 5'd0, 32'h0000_0999);
    v.wen = 3'b001; v.waddr[0] = 5'd0; v.wdata[0] = 32'h55;
    v.expData[0] = 32'h0;
    addVec(v);

    v = idle("port_disabled");
    v.raddr[0] = 5'd5; v.rf[0] = 32'h77; v.expData[0] = 32'h77;
    v.wen = 3'b001; v.waddr[0] = 5'd5; v.wdata[0] = 32'h11;
    addVec(v);

    v = rd0("exe_not_ready", 5'd3, 32'h3);
    v.wen = 3'b001; v.waddr[0] = 5'd3; v.rdy = 3'b000; v.expStall = 1'b1;
    addVec(v);

    v = rd0("young_not_ready", 5'd3, 32'h3);
    v.wen = 3'b011; v.waddr[0] = 5'd3; v.waddr[1] = 5'd3;
    v.wdata[1] = 32'h99; v.rdy = 3'b010; v.expStall = 1'b1;
    addVec(v);

    v = rd0("exe_ready", 5'd3, 32'h3);
    v.wen = 3'b001; v.waddr[0] = 5'd3; v.wdata[0] = 32'h33;
    v.expData[0] = 32'h33; v.expFwd = 2'b01;
    addVec(v);

    v = rd0("port1_stall", 5'd1, 32'h1);
    v.rden[1] = 1'b1; v.raddr[1] = 5'd3; v.rf[1] = 32'h3;
    v.wen = 3'b001; v.waddr[0] = 5'd3; v.rdy = 3'b000; v.expStall = 1'b1;
    addVec(v);

    v = rd0("ll_issue9", 5'd9, 32'h99);
    v.issue = 1'b1; v.iaddr = 5'd9;
    addVec(v);
    for (int k = 0; k < 4; k++) begin
      v = rd0("ll_wait9", 5'd9, 32'h99);
      v.expStall = 1'b1;
      addVec(v);
    end
    v = rd0("ll_done9", 5'd9, 32'h99);
    v.done = 1'b1; v.daddr = 5'd9; v.lldata = 32'hDEAD;
    v.expData[0] = 32'hDEAD; v.expFwd = 2'b01;
    addVec(v);
    addVec(rd0("ll_after9", 5'd9, 32'h99));

    v = rd0("ll_done_nonpend", 5'd12, 32'hC);
    v.done = 1'b1; v.daddr = 5'd12; v.lldata = 32'hBEEF;
    v.expData[0] = 32'hBEEF; v.expFwd = 2'b01;
    addVec(v);
    addVec(rd0("after_nonpend", 5'd12, 32'hC));

    v = idle("ll_issue10");
    v.issue = 1'b1; v.iaddr = 5'd10;
    addVec(v);
    v = rd0("done_and_issue10", 5'd10, 32'h10);
    v.issue = 1'b1; v.iaddr = 5'd10; v.done = 1'b1; v.daddr = 5'd10; v.lldata = 32'h1010;
    v.expData[0] = 32'h1010; v.expFwd = 2'b01;
    addVec(v);
    v = rd0("set_wins10", 5'd10, 32'h10);
    v.expStall = 1'b1;
    addVec(v);
    v = rd0("stage_over_pend", 5'd10, 32'h10);
    v.wen = 3'b001; v.waddr[0] = 5'd10; v.wdata[0] = 32'hABC;
    v.expData[0] = 32'hABC; v.expFwd = 2'b01;
    addVec(v);
    v = rd0("ll_done10", 5'd10, 32'h10);
    v.done = 1'b1; v.daddr = 5'd10; v.lldata = 32'h2020;
    v.expData[0] = 32'h2020; v.expFwd = 2'b01;
    addVec(v);
    addVec(rd0("after10", 5'd10, 32'h10));

    v = idle("issue9_a");
    v.issue = 1'b1; v.iaddr = 5'd9;
    addVec(v);
    v = idle("issue9_b");
    v.issue = 1'b1; v.iaddr = 5'd9;
    addVec(v);
    curErr = 1'b1;
    v = rd0("err_read9", 5'd9, 32'h99);
    v.expStall = 1'b1;
    addVec(v);

    v = rd0("flush", 5'd1, 32'h1);
    v.flush = 1'b1; v.issue = 1'b1; v.iaddr = 5'd11;
    addVec(v);
    v = rd0("after_flush", 5'd9, 32'h99);
    v.rden[1] = 1'b1; v.raddr[1] = 5'd11; v.rf[1] = 32'hB; v.expData[1] = 32'hB;
    addVec(v);

    // ---------------- reset ----------------
    reset = 1'b1;
    driveInputs(idle("init"));
    repeat (2) @(posedge clk);
    @(negedge clk);
    reset = 1'b0;

    runVec(idle("post_reset"));

    foreach (vecs[k]) runVec(vecs[k]);

    // ---------------- async reset while stalled ----------------
    v = idle("ms_issue9");
    v.issue = 1'b1; v.iaddr = 5'd9; v.expErr = 1'b1;
    runVec(v);
    for (int k = 0; k < 2; k++) begin
      v = rd0("ms_stall9", 5'd9, 32'h99);
      v.expStall = 1'b1; v.expErr = 1'b1;
      runVec(v);
    end
    @(negedge clk);
    v = rd0("ms_reset", 5'd9, 32'h99);
    applyStimulus(v);
    #1;
    reset = 1'b1;
    expStallCnt = '0;
    #1;
    checkOutput();
    @(negedge clk);
    reset = 1'b0;

    // ---------------- 17 stall cycles on a 4-bit counter ----------------
    for (int k = 0; k < 17; k++) begin
      v = rd0("wrap_stall", 5'd3, 32'h3);
      v.wen = 3'b001; v.waddr[0] = 5'd3; v.rdy = 3'b000; v.expStall = 1'b1;
      runVec(v);
    end
    runVec(idle("wrap_final"));
    compareField("wrap_final", "stall_cnt_17", 32'(bus.stall_cnt), 32'd1);

    compareField("end", "expect_queue_left", 32'(expQ.size()), 32'd0);

    $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
    $finish;
  end

endmodule
